// File: rtl/qam_pkg.sv
// qam_pkg: shared constants, state encoding and helpers for the qam frame controller.
package qam_pkg;
  localparam int DEF_LEN_W = 16;
  localparam logic [2:0] QAM_BPSK = 3'd0;
  localparam logic [2:0] QAM_QPSK = 3'd1;
  localparam logic [2:0] QAM_16   = 3'd2;
  localparam logic [2:0] QAM_64   = 3'd3;
  localparam logic [2:0] QAM_MAX  = 3'd4;
  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_STREAM, ST_DRAIN, ST_ABORT} state_e;
  function automatic logic qam_legal(input logic [2:0] code, input int max_code);
    return int'(code) <= max_code;
  endfunction
endpackage

// File: rtl/qam_frame_ctrl_if.sv
// qam_frame_ctrl_if: request, source and modulator signals of the frame controller.
interface qam_frame_ctrl_if
  import qam_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
) ();
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_qam;
  logic [LEN_W-1:0] req_len;
  logic [31:0]      src_data;
  logic             src_valid;
  logic             src_ready;
  logic [31:0]      mod_signal_in;
  logic [2:0]       mod_qam;
  logic             mod_valid_in;
  logic             mod_ready_out;
  logic             mod_error;
  modport master (
    input  req_valid, req_qam, req_len, src_data, src_valid, mod_ready_out, mod_error,
    output req_ready, src_ready, mod_signal_in, mod_qam, mod_valid_in
  );
  modport slave (
    output req_valid, req_qam, req_len, src_data, src_valid, mod_ready_out, mod_error,
    input  req_ready, src_ready, mod_signal_in, mod_qam, mod_valid_in
  );
endinterface

// File: rtl/qam_cyc_timer.sv
// qam_cyc_timer: loadable down-counter that parks at zero; done flags the zero count.
module qam_cyc_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] cnt_o,
  output logic         done_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= load_i ? val_i : cnt_q - W'(cnt_q != '0);
  assign cnt_o  = cnt_q;
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/qam_frame_ctrl.sv
// qam_frame_ctrl: frame sequencer that reprograms qam only between frames and
// gates exactly the requested number of source words into the modulator.
module qam_frame_ctrl
  import qam_pkg::*;
#(
  parameter int LEN_W      = DEF_LEN_W,
  parameter int MAX_QAM    = int'(QAM_MAX),
  parameter int SETTLE_CYC = 4,
  parameter int DRAIN_CYC  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  qam_frame_ctrl_if.master bus,
  input  logic             err_clr_i,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             req_err_o,
  output logic             abort_o,
  output logic [LEN_W-1:0] words_sent_o
);
  localparam int TW = $clog2((SETTLE_CYC > DRAIN_CYC ? SETTLE_CYC : DRAIN_CYC) + 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] DRAIN_LD  = TW'(DRAIN_CYC - 1);
  state_e           state_q;
  logic [LEN_W-1:0] len_q, words_q;
  logic [2:0]       qam_q;
  logic             req_ready_q, frame_done_q, req_err_q, abort_q;
  logic             stream, accept, xfer, last_xfer, tmr_load, tmr_done;
  logic [TW-1:0]    tmr_val, tmr_cnt;
  always_comb begin
    stream    = state_q == ST_STREAM;
    accept    = state_q == ST_IDLE && req_ready_q && bus.req_valid &&
                qam_legal(bus.req_qam, MAX_QAM) && bus.req_len != '0;
    xfer      = stream && bus.src_valid && bus.mod_ready_out;
    last_xfer = xfer && words_q + LEN_W'(1) == len_q;
    tmr_load  = (accept && bus.req_qam != qam_q) || last_xfer;
    tmr_val   = last_xfer ? DRAIN_LD : SETTLE_LD;
  end
  qam_cyc_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .cnt_o  (tmr_cnt),
    .done_o (tmr_done)
  );
  // Timer counts down to zero, so the final SETTLE/DRAIN cycle is the one with tmr_done.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      words_q      <= '0;
      qam_q        <= '0;
      req_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
      req_err_q    <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      req_err_q    <= 1'b0;
      req_ready_q  <= 1'b0;
      abort_q      <= bus.mod_error | (abort_q & ~err_clr_i);
      if (xfer) words_q <= words_q + LEN_W'(1);
      case (state_q)
        ST_IDLE: begin
          req_ready_q <= ~accept;
          if (req_ready_q && bus.req_valid) begin
            if (!qam_legal(bus.req_qam, MAX_QAM)) req_err_q <= 1'b1;
            else if (bus.req_len == '0) frame_done_q <= 1'b1;
            else begin
              len_q   <= bus.req_len;
              words_q <= '0;
              qam_q   <= bus.req_qam;
              state_q <= bus.req_qam != qam_q ? ST_SETTLE : ST_STREAM;
            end
          end
        end
        ST_SETTLE: if (tmr_done) state_q <= ST_STREAM;
        ST_STREAM:
          if (bus.mod_error) state_q <= ST_ABORT;
          else if (last_xfer) begin
            state_q      <= ST_DRAIN;
            frame_done_q <= DRAIN_CYC == 1;
          end
        // frame_done is raised for the last drain cycle; IDLE follows right after.
        ST_DRAIN:
          if (bus.mod_error) state_q <= ST_ABORT;
          else if (tmr_done) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
          end else frame_done_q <= tmr_cnt == TW'(1);
        ST_ABORT:
          if (err_clr_i && !bus.mod_error) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
          end
        default: state_q <= ST_IDLE;
      endcase
    end
  assign bus.req_ready     = req_ready_q;
  assign bus.src_ready     = stream && bus.mod_ready_out;
  assign bus.mod_valid_in  = stream && bus.src_valid;
  assign bus.mod_signal_in = stream ? bus.src_data : '0;
  assign bus.mod_qam       = qam_q;
  assign busy_o            = state_q != ST_IDLE;
  assign frame_done_o      = frame_done_q;
  assign req_err_o         = req_err_q;
  assign abort_o           = abort_q;
  assign words_sent_o      = words_q;
endmodule

// File: tb/tb_qam_frame_ctrl.sv
// tb_qam_frame_ctrl: randomized scenarios checked against a frame-level reference model.
module tb_qam_frame_ctrl;
  import qam_pkg::*;
  localparam int LEN_W = 16, SETTLE = 4, DRAIN = 8, MAXQ = 4;
  logic clk = 1'b0, rst_n = 1'b0, err_clr = 1'b0;
  logic busy, frame_done, req_err, abort;
  logic [LEN_W-1:0] words_sent;
  int tests = 0, fails = 0;
  logic [2:0] cur_qam;
  logic [31:0] src_q[$], got[$];
  int got_k[$], done_k[$];
  int qam_viol, leak, mirror_bad, req_err_n, busy_n, rdy_at_done, rdy_after_done;

  qam_frame_ctrl_if #(.LEN_W(LEN_W)) bus ();
  qam_frame_ctrl #(.LEN_W(LEN_W), .MAX_QAM(MAXQ), .SETTLE_CYC(SETTLE), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .err_clr_i(err_clr), .busy_o(busy),
    .frame_done_o(frame_done), .req_err_o(req_err), .abort_o(abort), .words_sent_o(words_sent)
  );
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.req_valid = 0; bus.req_qam = 0; bus.req_len = 0; bus.src_data = 0;
    bus.src_valid = 0; bus.mod_ready_out = 1; bus.mod_error = 0; err_clr = 0;
  endtask

  // Issues one request at cycle 0 and records what the modulator side sees per cycle k.
  task automatic drive_frame(input logic [2:0] qam, input int len, input int vprob, input int rmode,
                             input int err_after, input int ncyc, input bit rnd);
    int idx = 0, w = 0;
    bit err_done = 0;
    logic [2:0] pq;
    got.delete(); got_k.delete(); done_k.delete(); src_q.delete();
    qam_viol = 0; leak = 0; mirror_bad = 0; req_err_n = 0; busy_n = 0;
    rdy_at_done = -1; rdy_after_done = -1;
    for (int i = 0; i < len + 4; i++) src_q.push_back(rnd ? $urandom : 32'hFFFF_FFFE - i);
    while (bus.req_ready !== 1'b1 && w < 64) begin @(posedge clk); #1; w++; end
    tests++;
    if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL req_ready_wait: req_ready=%b required 1", bus.req_ready); end
    bus.req_valid = 1; bus.req_qam = qam; bus.req_len = LEN_W'(len);
    pq = bus.mod_qam;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) begin
        bus.req_valid = 0;
        bus.src_valid = $urandom_range(99) < vprob;
        bus.mod_ready_out = rmode == 0 ? 1'b1 : rmode == 1 ? k[0] : 1'($urandom_range(1));
        bus.mod_error = err_after >= 0 && !err_done && got.size() == err_after;
        if (bus.mod_error) begin bus.src_valid = 0; err_done = 1; end
      end
      bus.src_data = idx < src_q.size() ? src_q[idx] : 32'h0;
      #1;
      if (bus.mod_qam !== pq && bus.mod_valid_in) qam_viol++;
      pq = bus.mod_qam;
      if (got.size() >= len && (bus.src_ready || bus.mod_valid_in)) leak++;
      if (got.size() > 0 && got.size() < len && bus.src_ready !== bus.mod_ready_out) mirror_bad++;
      if (bus.mod_valid_in && bus.mod_ready_out) begin got.push_back(bus.mod_signal_in); got_k.push_back(k); end
      if (bus.src_valid && bus.src_ready) idx++;
      if (frame_done) begin done_k.push_back(k); rdy_at_done = bus.req_ready; end
      if (done_k.size() > 0 && k == done_k[0] + 1) rdy_after_done = bus.req_ready;
      if (req_err) req_err_n++;
      if (busy) busy_n++;
      @(posedge clk); #1;
      if (err_after < 0 && done_k.size() > 0 && k >= done_k[0] + 3) break;
    end
  endtask

  // Compares one completed frame with the model: first len offered words, done DRAIN after last.
  task automatic check_frame(input string name, input int len, input int gap, input bit exact);
    int bad = 0;
    for (int i = 0; i < len; i++) if (i >= got.size() || got[i] !== src_q[i]) bad++;
    tests++;
    if (bad != 0 || got.size() != len) begin
      fails++; $display("FAIL %s_words: got %0d words (%0d wrong), required %0d", name, got.size(), bad, len);
    end
    tests++;
    if (got_k.size() == 0 || (exact ? got_k[0] != 1 + gap : got_k[0] < 1 + gap)) begin
      fails++; $display("FAIL %s_first_word: cycle %0d, required %s%0d", name,
                        got_k.size() ? got_k[0] : -1, exact ? "" : ">=", 1 + gap);
    end
    tests++;
    if (done_k.size() != 1 || got_k.size() == 0 || done_k[0] != got_k[got_k.size()-1] + DRAIN) begin
      fails++; $display("FAIL %s_frame_done: %0d pulses first at %0d, required 1 at last word + %0d", name,
                        done_k.size(), done_k.size() ? done_k[0] : -1, DRAIN);
    end
    tests++;
    if (words_sent !== LEN_W'(len) || bus.mod_qam !== cur_qam || leak != 0 || qam_viol != 0) begin
      fails++; $display("FAIL %s_status: words_sent=%0d qam=%0d leak=%0d qam_viol=%0d, required %0d %0d 0 0",
                        name, words_sent, bus.mod_qam, leak, qam_viol, len, cur_qam);
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({busy, frame_done, req_err, abort, bus.req_ready, bus.src_ready, bus.mod_valid_in} !== 7'b0 ||
        words_sent !== '0 || bus.mod_qam !== 3'd0 || bus.mod_signal_in !== 32'h0) begin
      fails++; $display("FAIL reset_state: busy=%b ready=%b qam=%0d words=%0d, required all 0", busy, bus.req_ready, bus.mod_qam, words_sent);
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    tests++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_release: req_ready=%b busy=%b, required 1 0", bus.req_ready, busy);
    end
    cur_qam = 0;
  endtask

  task automatic test_basic();
    int gap = QAM_16 != cur_qam ? SETTLE : 0;
    drive_frame(QAM_16, 5, 100, 0, -1, 40, 0);
    cur_qam = QAM_16;
    check_frame("basic", 5, gap, 1);
    tests++;
    if (rdy_at_done != 0 || rdy_after_done != 1) begin
      fails++; $display("FAIL basic_ready_after_done: at=%0d after=%0d, required 0 1", rdy_at_done, rdy_after_done);
    end
  endtask

  task automatic test_back_to_back();
    int len = $urandom_range(6, 1);
    drive_frame(QAM_16, len, 100, 0, -1, 60, 1);
    check_frame("same_qam", len, 0, 1);
    len = $urandom_range(6, 1);
    drive_frame(QAM_QPSK, len, 100, 0, -1, 60, 1);
    cur_qam = QAM_QPSK;
    check_frame("new_qam", len, SETTLE, 1);
  endtask

  task automatic test_toggle_ready();
    int gap = QAM_QPSK != cur_qam ? SETTLE : 0;
    drive_frame(QAM_QPSK, 4, 100, 1, -1, 60, 1);
    check_frame("toggle", 4, gap, 0);
    tests++;
    if (mirror_bad != 0) begin fails++; $display("FAIL toggle_mirror: %0d cycles src_ready!=mod_ready_out, required 0", mirror_bad); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      logic [2:0] q = 3'($urandom_range(MAXQ));
      int len = $urandom_range(20, 1);
      int gap = q != cur_qam ? SETTLE : 0;
      drive_frame(q, len, $urandom_range(100, 30), 2, -1, 40 + 40 * len, 1);
      cur_qam = q;
      check_frame($sformatf("rand%0d", f), len, gap, 0);
    end
  endtask

  task automatic test_reject();
    logic [2:0] nq = 3'((int'(cur_qam) + 1) % (MAXQ + 1));
    drive_frame(3'd7, 3, 100, 0, -1, 10, 1);
    tests++;
    if (req_err_n != 1 || busy_n != 0 || got.size() != 0 || done_k.size() != 0 || bus.mod_qam !== cur_qam) begin
      fails++; $display("FAIL reject_qam7: req_err=%0d busy=%0d words=%0d done=%0d qam=%0d, required 1 0 0 0 %0d",
                        req_err_n, busy_n, got.size(), done_k.size(), bus.mod_qam, cur_qam);
    end
    drive_frame(3'($urandom_range(7, MAXQ + 1)), 2, 100, 0, -1, 10, 1);
    tests++;
    if (req_err_n != 1 || busy_n != 0) begin fails++; $display("FAIL reject_rand: req_err=%0d busy=%0d, required 1 0", req_err_n, busy_n); end
    drive_frame(nq, 0, 100, 0, -1, 10, 1);
    tests++;
    if (done_k.size() != 1 || done_k[0] != 1 || busy_n != 0 || req_err_n != 0 || leak != 0 || bus.mod_qam !== cur_qam) begin
      fails++; $display("FAIL zero_len: done=%0d at %0d busy=%0d err=%0d qam=%0d, required 1 at 1 0 0 %0d",
                        done_k.size(), done_k.size() ? done_k[0] : -1, busy_n, req_err_n, bus.mod_qam, cur_qam);
    end
  endtask

  task automatic test_abort();
    drive_frame(cur_qam, 6, 100, 0, 2, 20, 1);
    tests++;
    if (got.size() != 2 || done_k.size() != 0 || abort !== 1'b1 || words_sent !== LEN_W'(2) ||
        busy !== 1'b1 || bus.req_ready !== 1'b0 || bus.mod_valid_in !== 1'b0) begin
      fails++; $display("FAIL abort_state: words=%0d done=%0d abort=%b sent=%0d busy=%b ready=%b, required 2 0 1 2 1 0",
                        got.size(), done_k.size(), abort, words_sent, busy, bus.req_ready);
    end
    idle_inputs(); err_clr = 1; @(posedge clk); #1; err_clr = 0;
    tests++;
    if (busy !== 1'b0 || abort !== 1'b0 || bus.req_ready !== 1'b1) begin
      fails++; $display("FAIL abort_clear: busy=%b abort=%b ready=%b, required 0 0 1", busy, abort, bus.req_ready);
    end
    bus.mod_error = 1; @(posedge clk); #1; bus.mod_error = 0;
    tests++;
    if (abort !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL idle_error: abort=%b busy=%b, required 1 0", abort, busy); end
    bus.mod_error = 1; err_clr = 1; @(posedge clk); #1; bus.mod_error = 0;
    tests++;
    if (abort !== 1'b1) begin fails++; $display("FAIL error_beats_clear: abort=%b required 1", abort); end
    @(posedge clk); #1; err_clr = 0;
    tests++;
    if (abort !== 1'b0) begin fails++; $display("FAIL clear_abort: abort=%b required 0", abort); end
  endtask

  task automatic test_reset_mid_stream();
    int gap = QAM_16 != cur_qam ? SETTLE : 0;
    drive_frame(QAM_16, 10, 100, 0, -1, 4 + gap, 1);
    tests++;
    if (got.size() != 3 || words_sent !== LEN_W'(3)) begin
      fails++; $display("FAIL pre_reset: words=%0d sent=%0d, required 3 3", got.size(), words_sent);
    end
    rst_n = 0; #1;
    tests++;
    if ({busy, frame_done, bus.req_ready, bus.src_ready, bus.mod_valid_in} !== 5'b0 ||
        words_sent !== '0 || bus.mod_qam !== 3'd0 || bus.mod_signal_in !== 32'h0) begin
      fails++; $display("FAIL mid_reset: busy=%b src_ready=%b valid=%b sent=%0d qam=%0d, required all 0",
                        busy, bus.src_ready, bus.mod_valid_in, words_sent, bus.mod_qam);
    end
    @(negedge clk); rst_n = 1; cur_qam = 0;
    busy_n = 0; done_k.delete();
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (frame_done) done_k.push_back(k);
      if (busy) busy_n++;
    end
    tests++;
    if (done_k.size() != 0 || busy_n != 0) begin
      fails++; $display("FAIL post_reset_quiet: done=%0d busy=%0d, required 0 0", done_k.size(), busy_n);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_back_to_back();
    test_toggle_ready();
    test_random();
    test_reject();
    test_abort();
    test_reset_mid_stream();
    test_basic();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
